// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: synchronises and glitch-filters three Hall inputs, counts
// commutation edges per gate window and publishes saturated rpm and km/h once per window.
module hall_speed_meter #(
    parameter int GATE_CYCLES   = 5_000_000,
    parameter int FILTER_CYCLES = 16,
    parameter int RPM_SCALE     = 25,
    parameter int SPEED_MUL     = 3,
    parameter int SPEED_SHIFT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hall_in,
    output logic [13:0] engine_rev,
    output logic [8:0]  vehicle_speed,
    output logic        hall_fault,
    output logic        update
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_N  = FW'(FILTER_CYCLES);
    localparam logic [31:0]   RPM_MAX   = 32'd16383;
    localparam logic [31:0]   SPEED_MAX = 32'd511;

    logic [2:0]    sync1, sync2, cand, accepted, last_valid;
    logic [FW-1:0] stab_cnt, run_len;
    logic          have_valid, accept, code_invalid, edge_now, fault_now;
    logic [15:0]   edge_cnt, edge_total;
    logic          win_fault;
    logic [GW-1:0] gate_cnt;
    logic          terminal;
    logic [15:0]   lat_cnt;
    logic          lat_fault, lat_vld;
    logic [13:0]   rpm;
    logic          rpm_fault, rpm_vld;
    logic [31:0]   rpm_prod, speed_prod;
    logic [13:0]   rpm_next;
    logic [8:0]    speed_next;

    // cand holds last cycle's synchronised code, so run_len is the length of the current run
    always_comb begin
        run_len = FW'(1);
        if (sync2 == cand) begin
            if (stab_cnt >= FILTER_N) run_len = FILTER_N;
            else                      run_len = stab_cnt + FW'(1);
        end
        accept       = (sync2 != accepted) && (run_len >= FILTER_N);
        code_invalid = (sync2 == 3'b000) || (sync2 == 3'b111);
        fault_now    = accept && code_invalid;
        edge_now     = accept && !code_invalid && have_valid && (sync2 != last_valid);
        edge_total   = (edge_now && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;
        terminal     = (gate_cnt == GATE_LAST);
    end

    always_comb begin
        rpm_prod   = 32'(lat_cnt) * 32'(RPM_SCALE);
        rpm_next   = (rpm_prod > RPM_MAX) ? 14'h3FFF : rpm_prod[13:0];
        speed_prod = (32'(rpm) * 32'(SPEED_MUL)) >> SPEED_SHIFT;
        speed_next = (speed_prod > SPEED_MAX) ? 9'h1FF : speed_prod[8:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 3'b000;
            sync2      <= 3'b000;
            cand       <= 3'b000;
            stab_cnt   <= '0;
            accepted   <= 3'b000;
            last_valid <= 3'b000;
            have_valid <= 1'b0;
        end else begin
            sync1    <= hall_in;
            sync2    <= sync1;
            cand     <= sync2;
            stab_cnt <= run_len;
            if (accept) begin
                accepted <= sync2;
                if (!code_invalid) begin
                    have_valid <= 1'b1;
                    last_valid <= sync2;
                end
            end
        end
    end

    // An edge accepted on the terminal cycle is folded into the ending window via edge_total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt  <= '0;
            edge_cnt  <= 16'd0;
            win_fault <= 1'b0;
            lat_cnt   <= 16'd0;
            lat_fault <= 1'b0;
            lat_vld   <= 1'b0;
        end else begin
            lat_vld <= terminal;
            if (terminal) begin
                gate_cnt  <= '0;
                lat_cnt   <= edge_total;
                lat_fault <= win_fault | fault_now;
                edge_cnt  <= 16'd0;
                win_fault <= 1'b0;
            end else begin
                gate_cnt  <= gate_cnt + GW'(1);
                edge_cnt  <= edge_total;
                win_fault <= win_fault | fault_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpm           <= 14'd0;
            rpm_fault     <= 1'b0;
            rpm_vld       <= 1'b0;
            engine_rev    <= 14'd0;
            vehicle_speed <= 9'd0;
            hall_fault    <= 1'b0;
            update        <= 1'b0;
        end else begin
            rpm_vld <= lat_vld;
            update  <= rpm_vld;
            if (lat_vld) begin
                rpm       <= rpm_next;
                rpm_fault <= lat_fault;
            end
            if (rpm_vld) begin
                engine_rev    <= rpm;
                vehicle_speed <= speed_next;
                hall_fault    <= rpm_fault;
            end
        end
    end
endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: drives Hall code sequences and compares each window report
// against a segment-level model of filtering, edge counting and rpm/speed arithmetic.
module tb_hall_speed_meter;
    localparam int GATE  = 1000;
    localparam int GATE2 = 4000;
    localparam int FILT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst2_n = 1'b0;
    logic [2:0]  hall = 3'b001, hall2 = 3'b001;
    logic [13:0] engine_rev, engine_rev2;
    logic [8:0]  vehicle_speed, vehicle_speed2;
    logic        hall_fault, hall_fault2, update, update2;

    hall_speed_meter #(.GATE_CYCLES(GATE), .FILTER_CYCLES(FILT)) u_dut (
        .clk(clk), .rst_n(rst_n), .hall_in(hall), .engine_rev(engine_rev),
        .vehicle_speed(vehicle_speed), .hall_fault(hall_fault), .update(update));

    // Longer window so that a saturating number of edges fits through the filter
    hall_speed_meter #(.GATE_CYCLES(GATE2), .FILTER_CYCLES(FILT)) u_dut_sat (
        .clk(clk), .rst_n(rst2_n), .hall_in(hall2), .engine_rev(engine_rev2),
        .vehicle_speed(vehicle_speed2), .hall_fault(hall_fault2), .update(update2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  comm [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    logic [2:0]  seg_code[$];
    int          seg_hold[$];
    logic [23:0] exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          pos = 0;
    int          rel_cyc = 0;
    bit          m_have = 1'b0, m_fault = 1'b0;
    logic [2:0]  m_last = 3'b000;
    int          m_edges = 0;

    // A code held shorter than the filter never gets accepted; a longer one is judged by the edge rules
    function automatic void model_seg(input logic [2:0] code, input int hold, inout bit have,
                                      inout logic [2:0] last, inout int edges, inout bit fault);
        if (hold < FILT) return;
        if (code == 3'b000 || code == 3'b111) fault = 1'b1;
        else if (!have) begin have = 1'b1; last = code; end
        else if (code != last) begin edges = edges + 1; last = code; end
    endfunction

    function automatic logic [23:0] expect_word(input int edges, input bit fault);
        int r, s;
        r = edges * 25;
        if (r > 16383) r = 16383;
        s = (r * 3) / 256;
        if (s > 511) s = 511;
        return {fault, 9'(s), 14'(r)};
    endfunction

    task automatic push_seg(input logic [2:0] code, input int hold);
        seg_code.push_back(code);
        seg_hold.push_back(hold);
    endtask

    task automatic gen_commutations(input int n, input int hold, input bit fwd);
        for (int i = 0; i < n; i++) begin
            pos = fwd ? (pos + 1) % 6 : (pos + 5) % 6;
            push_seg(comm[pos], hold);
        end
    endtask

    task automatic gen_random(input bit glitches, input bit invalids);
        int total, r;
        total = 0;
        while (total < 700) begin
            r = $urandom_range(0, 9);
            if (glitches && r == 0) begin
                push_seg(comm[(pos + $urandom_range(1, 5)) % 6], $urandom_range(1, 2));
                push_seg(comm[pos], $urandom_range(6, 12));
                total += 14;
            end else if (invalids && r == 1) begin
                push_seg(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111, $urandom_range(6, 10));
                pos = (pos + $urandom_range(1, 5)) % 6;
                push_seg(comm[pos], $urandom_range(6, 12));
                total += 22;
            end else begin
                pos = ($urandom_range(0, 3) != 0) ? (pos + 1) % 6 : (pos + 5) % 6;
                push_seg(comm[pos], $urandom_range(6, 14));
                total += 14;
            end
        end
    endtask

    task automatic drive_segs1();
        while (seg_code.size() > 0) begin
            logic [2:0] c;
            int h;
            c = seg_code.pop_front();
            h = seg_hold.pop_front();
            hall = c;
            repeat (h) @(negedge clk);
            model_seg(c, h, m_have, m_last, m_edges, m_fault);
        end
    endtask

    task automatic close_window1();
        exp_q.push_back(expect_word(m_edges, m_fault));
        m_edges = 0;
        m_fault = 1'b0;
    endtask

    task automatic check_window1(input string name, input int exp_lat);
        int n;
        logic [23:0] e;
        n = 0;
        while (update !== 1'b1 && n < GATE + 20) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h0;
        vectors++;
        if (update !== 1'b1) begin
            miscompares++;
            $display("FAIL %s update: no strobe within %0d cycles", name, n);
            return;
        end
        if (exp_lat >= 0) begin
            vectors++;
            if (cyc - rel_cyc !== exp_lat) begin
                miscompares++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc - rel_cyc, exp_lat);
            end
        end
        vectors++;
        if (engine_rev !== e[13:0]) begin
            miscompares++;
            $display("FAIL %s engine_rev: got %0d expected %0d", name, engine_rev, e[13:0]);
        end
        vectors++;
        if (vehicle_speed !== e[22:14]) begin
            miscompares++;
            $display("FAIL %s vehicle_speed: got %0d expected %0d", name, vehicle_speed, e[22:14]);
        end
        vectors++;
        if (hall_fault !== e[23]) begin
            miscompares++;
            $display("FAIL %s hall_fault: got %0b expected %0b", name, hall_fault, e[23]);
        end
        @(negedge clk);
        vectors++;
        if (update !== 1'b0) begin
            miscompares++;
            $display("FAIL %s update width: got %0b expected 0 one cycle later", name, update);
        end
    endtask

    task automatic align1();
        int n;
        n = 0;
        while (update !== 1'b1 && n < GATE + 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        m_edges = 0;
        m_fault = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({engine_rev, vehicle_speed, hall_fault, update} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset outputs: got %h expected 0",
                     {engine_rev, vehicle_speed, hall_fault, update});
        end
        rst_n = 1'b1;
        rel_cyc = cyc;
        m_have = 1'b0;
        push_seg(comm[pos], 20);
        drive_segs1();
        close_window1();
        check_window1("reset_first_update", GATE + 2);
    endtask

    task automatic test_commutation();
        gen_commutations(40, 10, 1'b1);
        drive_segs1();
        close_window1();
        check_window1("commutation40", -1);
    endtask

    task automatic test_saturation();
        bit have2, fault2;
        logic [2:0] last2;
        int edges2, p2, n;
        logic [23:0] e;
        have2 = 1'b0; fault2 = 1'b0; last2 = 3'b000; edges2 = 0; p2 = 0;
        @(negedge clk);
        rst2_n = 1'b1;
        hall2 = comm[0];
        repeat (10) @(negedge clk);
        model_seg(comm[0], 10, have2, last2, edges2, fault2);
        for (int i = 0; i < 700; i++) begin
            p2 = ($urandom_range(0, 1) == 0) ? (p2 + 1) % 6 : (p2 + 5) % 6;
            hall2 = comm[p2];
            repeat (5) @(negedge clk);
            model_seg(comm[p2], 5, have2, last2, edges2, fault2);
        end
        for (int w = 0; w < 2; w++) begin
            e = expect_word(edges2, fault2);
            edges2 = 0;
            fault2 = 1'b0;
            n = 0;
            while (update2 !== 1'b1 && n < GATE2 + 20) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (update2 !== 1'b1) begin
                miscompares++;
                $display("FAIL saturation update: no strobe in window %0d", w);
            end else begin
                vectors++;
                if (engine_rev2 !== e[13:0]) begin
                    miscompares++;
                    $display("FAIL saturation engine_rev w%0d: got %0d expected %0d", w, engine_rev2, e[13:0]);
                end
                vectors++;
                if (vehicle_speed2 !== e[22:14]) begin
                    miscompares++;
                    $display("FAIL saturation vehicle_speed w%0d: got %0d expected %0d",
                             w, vehicle_speed2, e[22:14]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_glitch();
        align1();
        for (int i = 0; i < 50; i++) begin
            push_seg(comm[(pos + 1) % 6], 2);
            push_seg(comm[pos], 8);
        end
        drive_segs1();
        close_window1();
        check_window1("glitch_filter", -1);
    endtask

    task automatic test_fault();
        push_seg(comm[pos], 10);
        push_seg(3'b000, 10);
        pos = (pos + 1) % 6;
        push_seg(comm[pos], 10);
        drive_segs1();
        close_window1();
        check_window1("invalid_code_window", -1);
        gen_random(1'b1, 1'b0);
        drive_segs1();
        close_window1();
        check_window1("clean_after_fault", -1);
    endtask

    task automatic test_reset_mid_window();
        gen_commutations(20, 10, 1'b1);
        drive_segs1();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({engine_rev, vehicle_speed, hall_fault, update} !== 25'd0) begin
            miscompares++;
            $display("FAIL mid_reset outputs: got %h expected 0",
                     {engine_rev, vehicle_speed, hall_fault, update});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        m_have = 1'b0;
        m_edges = 0;
        m_fault = 1'b0;
        push_seg(comm[pos], 10);
        gen_random(1'b1, 1'b1);
        drive_segs1();
        close_window1();
        check_window1("after_mid_reset", GATE + 2);
    endtask

    task automatic test_random();
        for (int w = 0; w < 3; w++) begin
            gen_random(1'b1, 1'b1);
            drive_segs1();
            close_window1();
            check_window1("random_window", -1);
        end
    endtask

    initial begin
        test_reset();
        test_commutation();
        test_saturation();
        test_glitch();
        test_fault();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
